// File: rtl/stack_pkg.sv
// Shared definitions for the hardware stack controller.
// Holds the controller state encoding, the operation encoding, the per-op
// word counts, the default stack geometry, and small decode helpers.
package stack_pkg;

  // Default stack geometry: 10-bit address, empty stack at the top word.
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_SP_INIT = (1 << DEF_ADDR_W) - 1;

  // Controller states; busy is asserted in every state except ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH     = 2'd1,
    ST_POP_RD   = 2'd2,
    ST_POP_LAST = 2'd3
  } state_e;

  // Operation latched at accept time.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RTI  = 3'd6
  } op_e;

  // Number of 16-bit words each operation moves.
  localparam logic [1:0] WORDS_PUSH = 2'd1;
  localparam logic [1:0] WORDS_POP  = 2'd1;
  localparam logic [1:0] WORDS_CALL = 2'd2;
  localparam logic [1:0] WORDS_RET  = 2'd2;
  localparam logic [1:0] WORDS_INT  = 2'd3;
  localparam logic [1:0] WORDS_RTI  = 2'd3;

  function automatic logic [1:0] op_words(input op_e op);
    case (op)
      OP_PUSH: return WORDS_PUSH;
      OP_POP:  return WORDS_POP;
      OP_CALL: return WORDS_CALL;
      OP_RET:  return WORDS_RET;
      OP_INT:  return WORDS_INT;
      OP_RTI:  return WORDS_RTI;
      default: return 2'd0;
    endcase
  endfunction

  // True for operations that write to the stack (grow it downwards).
  function automatic logic op_is_push(input op_e op);
    return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

endpackage

// File: rtl/sp_reg.sv
// Stack pointer register: ADDR_W-bit up/down counter.
// Ports: clk_i clock; rst_ni synchronous active-low reset (loads SP_INIT);
//        en_i count enable; up_i direction (1 = +1, 0 = -1); sp_o pointer.
// Arithmetic is modulo 2^ADDR_W.
module sp_reg
  import stack_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SP_INIT = (1 << ADDR_W) - 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              up_i,
  output logic [ADDR_W-1:0] sp_o
);

  logic [ADDR_W-1:0] sp_d;
  logic [ADDR_W-1:0] sp_q;

  // Next pointer value: hold, increment or decrement.
  always_comb begin
    sp_d = sp_q;
    if (en_i) begin
      if (up_i) begin
        sp_d = sp_q + ADDR_W'(1);
      end else begin
        sp_d = sp_q - ADDR_W'(1);
      end
    end else begin
      sp_d = sp_q;
    end
  end

  // Pointer register with synchronous reset to the empty-stack value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_q <= ADDR_W'(SP_INIT);
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack controller for push/pop/call/ret/int/rti.
// Inputs : clk, rst (sync active-low), six op requests (sampled in IDLE),
//          data_in (push word), pc_in (return PC), flags_in (CCR),
//          mem_rdata (valid the cycle after mem_re).
// Outputs: mem_addr/mem_we/mem_re/mem_wdata to the stack RAM, sp, busy,
//          done/err one-cycle pulses, popped data_out/pc_out/flags_out.
// Stack grows down: sp points at the next free word.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SP_INIT = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              int_req,
  input  logic              rti_req,
  input  logic [15:0]       data_in,
  input  logic [31:0]       pc_in,
  input  logic [3:0]        flags_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       data_out,
  output logic [31:0]       pc_out,
  output logic [3:0]        flags_out
);

  typedef logic [ADDR_W:0] spx_t;
  localparam logic [ADDR_W-1:0] SP_INIT_V = ADDR_W'(SP_INIT);

  state_e            state_q;
  op_e               op_q;
  op_e               req_op_s;
  logic [1:0]        req_n_s;
  logic [2:0][15:0]  req_words_s;
  logic              fits_s;
  logic [2:0][15:0]  words_q;
  logic [1:0][15:0]  cap_q;
  logic [1:0]        idx_q;
  logic [1:0]        left_q;
  logic              first_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [15:0]       mem_wdata_q;
  logic              done_q;
  logic              err_q;
  logic [15:0]       data_q;
  logic [31:0]       pc_q;
  logic [3:0]        flags_q;
  logic [15:0]       res_data_s;
  logic [31:0]       res_pc_s;
  logic [3:0]        res_flags_s;
  logic [ADDR_W-1:0] sp_s;
  logic              sp_en_s;
  logic              sp_up_s;

  // sp moves once per PUSH write cycle (down) and once per read cycle (up).
  assign sp_en_s = (state_q == ST_PUSH) || (state_q == ST_POP_RD);
  assign sp_up_s = (state_q == ST_POP_RD);

  sp_reg #(
    .ADDR_W (ADDR_W),
    .SP_INIT(SP_INIT)
  ) u_sp_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (sp_en_s),
    .up_i  (sp_up_s),
    .sp_o  (sp_s)
  );

  // Request arbitration, word list in push order and stack-space check.
  always_comb begin
    req_op_s    = OP_NONE;
    req_words_s = '0;
    if (int_req) begin
      req_op_s = OP_INT;
    end else if (rti_req) begin
      req_op_s = OP_RTI;
    end else if (ret_req) begin
      req_op_s = OP_RET;
    end else if (call_req) begin
      req_op_s = OP_CALL;
    end else if (pop_req) begin
      req_op_s = OP_POP;
    end else if (push_req) begin
      req_op_s = OP_PUSH;
    end else begin
      req_op_s = OP_NONE;
    end
    req_n_s = op_words(req_op_s);
    case (req_op_s)
      OP_PUSH: req_words_s[0] = data_in;
      OP_CALL: begin
        req_words_s[0] = pc_in[15:0];
        req_words_s[1] = pc_in[31:16];
      end
      OP_INT: begin
        req_words_s[0] = {12'h000, flags_in};
        req_words_s[1] = pc_in[15:0];
        req_words_s[2] = pc_in[31:16];
      end
      default: req_words_s = '0;
    endcase
    // Widened compare so sp+1 at the top of memory does not wrap.
    if (op_is_push(req_op_s)) begin
      fits_s = (spx_t'(sp_s) + spx_t'(1)) >= spx_t'(req_n_s);
    end else begin
      fits_s = spx_t'(SP_INIT_V - sp_s) >= spx_t'(req_n_s);
    end
  end

  // Final pop result: the last word comes straight from mem_rdata so the
  // results are already valid in the POP_LAST (done) cycle.
  always_comb begin
    res_data_s  = data_q;
    res_pc_s    = pc_q;
    res_flags_s = flags_q;
    case (op_q)
      OP_POP: res_data_s = mem_rdata;
      OP_RET: res_pc_s   = {cap_q[0], mem_rdata};
      OP_RTI: begin
        res_pc_s    = {cap_q[0], cap_q[1]};
        res_flags_s = mem_rdata[3:0];
      end
      default: res_data_s = data_q;
    endcase
  end

  // Controller FSM with registered memory strobes and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      words_q     <= '0;
      cap_q       <= '0;
      idx_q       <= 2'd0;
      left_q      <= 2'd0;
      first_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= 16'h0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= 16'h0000;
      pc_q        <= 32'h0000_0000;
      flags_q     <= 4'h0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The err cycle acts as the handshake: the still-held request
          // that caused it is not accepted a second time.
          if ((req_op_s != OP_NONE) && !err_q) begin
            op_q    <= req_op_s;
            words_q <= req_words_s;
            if (!fits_s) begin
              err_q <= 1'b1;
            end else if (op_is_push(req_op_s)) begin
              state_q     <= ST_PUSH;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= sp_s;
              mem_wdata_q <= req_words_s[0];
              idx_q       <= 2'd1;
              left_q      <= req_n_s - 2'd1;
              done_q      <= (req_n_s == 2'd1);
            end else begin
              state_q    <= ST_POP_RD;
              mem_re_q   <= 1'b1;
              mem_addr_q <= sp_s + ADDR_W'(1);
              idx_q      <= 2'd0;
              left_q     <= req_n_s - 2'd1;
              first_q    <= 1'b1;
            end
          end
        end
        ST_PUSH: begin
          if (left_q != 2'd0) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= sp_s - ADDR_W'(1);
            mem_wdata_q <= words_q[idx_q];
            idx_q       <= idx_q + 2'd1;
            left_q      <= left_q - 2'd1;
            done_q      <= (left_q == 2'd1);
          end else begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
          end
        end
        ST_POP_RD: begin
          first_q <= 1'b0;
          // From the second read cycle on, mem_rdata holds the previous read.
          if (!first_q) begin
            cap_q[idx_q[0]] <= mem_rdata;
            idx_q           <= idx_q + 2'd1;
          end
          if (left_q != 2'd0) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= sp_s + ADDR_W'(2);
            left_q     <= left_q - 2'd1;
          end else begin
            state_q    <= ST_POP_LAST;
            mem_addr_q <= '0;
            done_q     <= 1'b1;
          end
        end
        ST_POP_LAST: begin
          data_q  <= res_data_s;
          pc_q    <= res_pc_s;
          flags_q <= res_flags_s;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_wdata = mem_wdata_q;
  assign sp        = sp_s;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign data_out  = (state_q == ST_POP_LAST) ? res_data_s  : data_q;
  assign pc_out    = (state_q == ST_POP_LAST) ? res_pc_s    : pc_q;
  assign flags_out = (state_q == ST_POP_LAST) ? res_flags_s : flags_q;

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, stack address width.
REQ-002 SHALL have parameter SP_INIT, default 2^ADDR_W-1, empty-stack SP value (stack grows down).
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports push_req, pop_req, call_req, ret_req, int_req, rti_req  in  1 each  operation requests, sampled only in IDLE.
REQ-006 SHALL have ports data_in (in, 16, push word), pc_in (in, 32, return PC), flags_in (in, 4, CCR to save).
REQ-007 SHALL have ports mem_addr (out, ADDR_W), mem_we (out, 1), mem_re (out, 1), mem_wdata (out, 16), mem_rdata (in, 16, valid the cycle after mem_re).
REQ-008 SHALL have outputs sp (ADDR_W), busy (1), done (1), err (1), data_out (16), pc_out (32), flags_out (4).

Function
REQ-009 SHALL implement states IDLE, PUSH, POP_RD and POP_LAST; busy=1 in every state except IDLE.
REQ-010 In IDLE with several requests high, SHALL accept exactly one, priority int > rti > ret > call > pop > push.
REQ-011 Word counts SHALL be: push=1, call=2, int=3, pop=1, ret=2, rti=3.
REQ-012 Push order SHALL be: call = PC[15:0], then PC[31:16]; int = {12'b0, flags}, then PC[15:0], then PC[31:16].
REQ-013 Pop order SHALL be the exact reverse of REQ-012; rti SHALL restore pc_out and flags_out.
REQ-014 Accept at edge T SHALL latch op, operands and word count; the first memory cycle is T+1.
REQ-015 In PUSH, each cycle SHALL drive mem_we=1, mem_addr=sp and mem_wdata=the next word, then decrement sp at the edge (one word per cycle).
REQ-016 In POP_RD, each cycle SHALL increment sp and drive mem_re=1 with mem_addr=sp+1; the word SHALL be captured one cycle later, so reads and captures overlap.
REQ-017 An n-word push SHALL complete in n cycles, with done pulsed in the last write cycle.
REQ-018 An n-word pop SHALL complete in n+1 cycles, with done pulsed in POP_LAST (the capture of the final word); results SHALL be valid from that cycle.
REQ-019 Overflow: a push-type op with (sp+1) < word count SHALL pulse err in cycle T+1, perform no memory access, leave sp unchanged and return to IDLE.
REQ-020 Underflow: a pop-type op with (SP_INIT-sp) < word count SHALL behave the same as REQ-019.
REQ-021 sp arithmetic SHALL be modulo 2^ADDR_W; REQ-019/020 guarantee that no wrap is ever reached.
REQ-022 Requests arriving while busy SHALL be ignored and not queued; the requester holds the request until done or err.
REQ-023 mem_we and mem_re SHALL never both be 1; both SHALL be 0 in IDLE.
REQ-024 done and err SHALL each be one-cycle pulses and SHALL never be high together.
REQ-025 data_out, pc_out and flags_out SHALL hold their last popped values until overwritten.

Reset
REQ-026 With rst=0 at an edge: state=IDLE, sp=SP_INIT, all outputs 0 except sp; this applies mid-operation and abandons the op without done.
REQ-027 A reset in the same cycle as a request SHALL take precedence; the request is dropped.

Structure
REQ-028 Package stack_pkg SHALL hold the state enum, op encoding, per-op word-count constants and default SP_INIT.
REQ-029 Sub-module sp_reg SHALL hold the stack pointer: an ADDR_W up/down counter with enable, direction and sync active-low reset to SP_INIT.
REQ-030 Target size is 150-300 lines of RTL.

Verification (ADDR_W=10)
REQ-031 Reset, then push_req with data_in=16'hBEEF -> write addr 1023 at T+1, done at T+1, sp=1022.
REQ-032 call with pc_in=32'h1234_5678, then ret -> writes 1023=5678 and 1022=1234; ret completes in 3 cycles with pc_out=32'h1234_5678, sp=1023.
REQ-033 int (flags=4'hA, pc=32'h0000_0040), then rti -> 3 writes and 4 read cycles; flags_out=4'hA, pc_out=32'h40, sp back to 1023.
REQ-034 pop on an empty stack -> err at T+1, no mem_re, sp=1023; call at sp=0 -> err, no mem_we.
REQ-035 int_req and push_req high together -> int served first; push is ignored until idle and then served on a re-request.
REQ-036 rst=0 during the second cycle of a call -> IDLE next cycle, sp=1023, no done pulse.
